// File: rtl/mips_core_pkg.sv
// Shared core types: ROB entry layout, instruction classes and retirement FSM states.
package mips_core_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 26;

    typedef enum logic [1:0] {
        INST_ALU = 2'd0,
        INST_MEM = 2'd1,
        INST_BR  = 2'd2,
        INST_SYS = 2'd3
    } InstType;

    typedef enum logic [1:0] {
        COMMIT = 2'd0,
        STORE  = 2'd1,
        HALT   = 2'd2
    } CommitState;

    typedef struct packed {
        logic                  valid;
        logic                  ready;
        InstType               inst_type;
        logic                  is_load;
        logic [5:0]            reg_dest;
        logic [4:0]            logic_reg_dest;
        logic [DATA_WIDTH-1:0] value;
        logic [ADDR_WIDTH-1:0] mem_dest;
        logic                  pass;
        logic                  fail;
        logic                  done;
    } rob_entry;

    function automatic logic is_store(input rob_entry e);
        return (e.inst_type == INST_MEM) && !e.is_load;
    endfunction

endpackage

// File: rtl/rob_commit_unit.sv
// In-order ROB retirement: RF/RAT writeback, store release with timeout, MTC0 status.
module rob_commit_unit
    import mips_core_pkg::*;
#(
    parameter int COUNT_WIDTH = 32,
    parameter int ST_TIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   head_valid,
    input  rob_entry               head_entry,
    input  logic                   flush,
    output logic                   pop,
    output logic                   rf_we,
    output logic [5:0]             rf_waddr,
    output logic [DATA_WIDTH-1:0]  rf_wdata,
    output logic                   arch_we,
    output logic [4:0]             arch_lreg,
    output logic [5:0]             arch_preg,
    output logic                   st_req,
    output logic [ADDR_WIDTH-1:0]  st_addr,
    output logic [DATA_WIDTH-1:0]  st_data,
    input  logic                   st_ack,
    output logic                   st_err,
    output logic                   pass_o,
    output logic                   fail_o,
    output logic                   done_o,
    output logic [COUNT_WIDTH-1:0] retired_cnt
);

    localparam int TW = $clog2(ST_TIMEOUT + 2);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(ST_TIMEOUT);

    CommitState    state;
    logic          committable;
    logic          writes_reg;
    logic [TW-1:0] tmo_cnt;

    // Same-cycle retirement strobes; rst_n gating keeps them low while reset is held.
    always_comb begin
        pop         = 1'b0;
        writes_reg  = 1'b0;
        committable = rst_n && head_valid && head_entry.valid && head_entry.ready
                      && (state == COMMIT) && !flush;
        if (state == STORE) begin
            pop = rst_n && st_ack;
        end else if (committable) begin
            case (head_entry.inst_type)
                INST_ALU: begin
                    pop        = 1'b1;
                    writes_reg = 1'b1;
                end
                INST_MEM: begin
                    pop        = head_entry.is_load;
                    writes_reg = head_entry.is_load;
                end
                default: pop = 1'b1;
            endcase
        end
        rf_we     = writes_reg && (head_entry.logic_reg_dest != 5'd0);
        arch_we   = rf_we;
        rf_waddr  = rf_we   ? head_entry.reg_dest       : '0;
        rf_wdata  = rf_we   ? head_entry.value          : '0;
        arch_lreg = arch_we ? head_entry.logic_reg_dest : '0;
        arch_preg = arch_we ? head_entry.reg_dest       : '0;
    end

    // Retirement FSM, store port registers and sticky MTC0 status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COMMIT;
            st_req  <= 1'b0;
            st_addr <= '0;
            st_data <= '0;
            pass_o  <= 1'b0;
            fail_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (state)
                COMMIT: begin
                    if (committable && is_store(head_entry)) begin
                        state   <= STORE;
                        st_req  <= 1'b1;
                        st_addr <= head_entry.mem_dest;
                        st_data <= head_entry.value;
                    end else if (committable && head_entry.inst_type == INST_SYS) begin
                        pass_o <= pass_o | head_entry.pass;
                        fail_o <= fail_o | head_entry.fail;
                        if (head_entry.done) begin
                            done_o <= 1'b1;
                            state  <= HALT;
                        end
                    end
                end
                STORE: begin
                    // flush is deliberately ignored here: the store is already architectural.
                    if (st_ack) begin
                        state   <= COMMIT;
                        st_req  <= 1'b0;
                        st_addr <= '0;
                        st_data <= '0;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

    // Retired-instruction counter and store-timeout watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            tmo_cnt     <= '0;
            st_err      <= 1'b0;
        end else begin
            if (pop) begin
                retired_cnt <= retired_cnt + COUNT_WIDTH'(1);
            end
            if (state == STORE && st_ack) begin
                tmo_cnt <= '0;
            end else if (state == STORE && ST_TIMEOUT != 0 && !st_err) begin
                tmo_cnt <= tmo_cnt + TW'(1);
                if (tmo_cnt + TW'(1) == TMO_LIMIT) begin
                    st_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: directed scenarios plus randomized traffic
// compared every cycle against a behavioural retirement model.
module tb_rob_commit_unit;
    import mips_core_pkg::*;

    localparam int CW  = 4;
    localparam int TMO = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  head_valid = 1'b0;
    rob_entry              head_entry = '0;
    logic                  flush = 1'b0;
    logic                  st_ack = 1'b0;
    logic                  pop, rf_we, arch_we, st_req, st_err, pass_o, fail_o, done_o;
    logic [5:0]            rf_waddr, arch_preg;
    logic [4:0]            arch_lreg;
    logic [DATA_WIDTH-1:0] rf_wdata, st_data;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [CW-1:0]         retired_cnt;

    always #5 clk = ~clk;

    rob_commit_unit #(.COUNT_WIDTH(CW), .ST_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .head_valid(head_valid), .head_entry(head_entry),
        .flush(flush), .pop(pop), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .arch_we(arch_we), .arch_lreg(arch_lreg), .arch_preg(arch_preg),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack),
        .st_err(st_err), .pass_o(pass_o), .fail_o(fail_o), .done_o(done_o),
        .retired_cnt(retired_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: what has architecturally happened so far.
    bit                    m_halted, m_pending, m_err, m_pass, m_fail, m_done;
    int                    m_wait, m_retired;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit head_ok();
        return head_valid && head_entry.valid && head_entry.ready && !m_halted && !m_pending && !flush;
    endfunction

    function automatic bit head_is_store();
        return head_entry.inst_type == INST_MEM && !head_entry.is_load;
    endfunction

    task automatic model_reset();
        m_halted = 0; m_pending = 0; m_err = 0; m_pass = 0; m_fail = 0; m_done = 0;
        m_wait = 0; m_retired = 0; m_addr = '0; m_data = '0;
    endtask

    task automatic model_compare();
        bit exp_pop, exp_wr;
        exp_pop = m_pending ? st_ack : (head_ok() && !head_is_store());
        exp_wr  = head_ok() && head_entry.logic_reg_dest != 0 &&
                  (head_entry.inst_type == INST_ALU || (head_entry.inst_type == INST_MEM && head_entry.is_load));
        check("pop", pop, exp_pop);
        check("rf_we", rf_we, exp_wr);
        check("arch_we", arch_we, exp_wr);
        if (exp_wr) begin
            check("rf_waddr", rf_waddr, head_entry.reg_dest);
            check("rf_wdata", rf_wdata, head_entry.value);
            check("arch_lreg", arch_lreg, head_entry.logic_reg_dest);
            check("arch_preg", arch_preg, head_entry.reg_dest);
        end
        check("st_req", st_req, m_pending);
        if (m_pending) begin
            check("st_addr", st_addr, m_addr);
            check("st_data", st_data, m_data);
        end
        check("st_err", st_err, m_err);
        check("pass_o", pass_o, m_pass);
        check("fail_o", fail_o, m_fail);
        check("done_o", done_o, m_done);
        check("retired_cnt", retired_cnt, m_retired % (1 << CW));
    endtask

    task automatic model_update();
        if (m_pending) begin
            if (st_ack) begin
                m_pending = 0;
                m_wait = 0;
                m_retired++;
            end else if (TMO != 0 && !m_err) begin
                m_wait++;
                if (m_wait >= TMO) m_err = 1;
            end
        end else if (head_ok()) begin
            if (head_is_store()) begin
                m_pending = 1;
                m_addr = head_entry.mem_dest;
                m_data = head_entry.value;
            end else begin
                m_retired++;
                if (head_entry.inst_type == INST_SYS) begin
                    m_pass |= head_entry.pass;
                    m_fail |= head_entry.fail;
                    if (head_entry.done) begin
                        m_done = 1;
                        m_halted = 1;
                    end
                end
            end
        end
    endtask

    // Apply inputs just after a rising edge and compare at the following falling edge.
    task automatic drive(input rob_entry e, input bit hv, input bit fl, input bit ack);
        head_entry = e; head_valid = hv; flush = fl; st_ack = ack;
        @(negedge clk);
        model_compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; head_valid = 0; flush = 0; st_ack = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        tick();
    endtask

    function automatic rob_entry mk(input InstType t, input bit ld, input logic [4:0] lreg,
                                    input logic [5:0] preg, input logic [31:0] val,
                                    input logic [25:0] addr, input bit p, input bit f, input bit d);
        rob_entry e;
        e = '0;
        e.valid = 1; e.ready = 1; e.inst_type = t; e.is_load = ld;
        e.logic_reg_dest = lreg; e.reg_dest = preg; e.value = val; e.mem_dest = addr;
        e.pass = p; e.fail = f; e.done = d;
        return e;
    endfunction

    function automatic rob_entry rand_entry();
        rob_entry e;
        e.valid = ($urandom % 8) != 0;
        e.ready = ($urandom % 4) != 0;
        e.inst_type = InstType'($urandom % 4);
        e.is_load = $urandom % 2;
        e.reg_dest = 6'($urandom);
        e.logic_reg_dest = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
        e.value = $urandom;
        e.mem_dest = 26'($urandom);
        e.pass = ($urandom % 4) == 0;
        e.fail = ($urandom % 8) == 0;
        e.done = ($urandom % 24) == 0;
        return e;
    endfunction

    rob_entry alu_t0, alu_zero, st_e, sys_pass, sys_done, idle_e;

    initial begin
        alu_t0   = mk(INST_ALU, 0, 5'd8, 6'd40, 32'h1234, '0, 0, 0, 0);
        alu_zero = mk(INST_ALU, 0, 5'd0, 6'd41, 32'h55, '0, 0, 0, 0);
        st_e     = mk(INST_MEM, 0, 5'd3, 6'd7, 32'hDEAD, 26'h100, 0, 0, 0);
        sys_pass = mk(INST_SYS, 0, 5'd0, 6'd0, 32'h0, '0, 1, 0, 0);
        sys_done = mk(INST_SYS, 0, 5'd0, 6'd0, 32'h0, '0, 0, 0, 1);
        idle_e   = '0;

        do_reset();
        drive(idle_e, 0, 0, 0);
        check("reset_cnt", retired_cnt, 0);
        check("reset_st_req", st_req, 0);
        check("reset_done", done_o, 0);
        tick();

        // ALU with a real destination retires and writes in the same cycle.
        drive(alu_t0, 1, 0, 0);
        check("alu_pop", pop, 1);
        check("alu_rf_we", rf_we, 1);
        check("alu_waddr", rf_waddr, 40);
        check("alu_wdata", rf_wdata, 32'h1234);
        check("alu_lreg", arch_lreg, 8);
        tick();
        drive(alu_zero, 1, 0, 0);
        check("alu_cnt1", retired_cnt, 1);
        check("zero_pop", pop, 1);
        check("zero_rf_we", rf_we, 0);
        check("zero_arch_we", arch_we, 0);
        tick();

        // Store acknowledged on its third request cycle.
        drive(st_e, 1, 0, 0);
        check("st_issue_pop", pop, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(st_e, 1, 0, i == 2);
            check("st_req_hold", st_req, 1);
            check("st_addr_hold", st_addr, 26'h100);
            check("st_data_hold", st_data, 32'hDEAD);
            check("st_pop_ack", pop, i == 2);
            tick();
        end
        drive(idle_e, 0, 0, 0);
        check("st_req_drop", st_req, 0);
        check("st_cnt3", retired_cnt, 3);
        tick();

        // Flush while the store waits must not cancel it.
        drive(st_e, 1, 0, 0);
        tick();
        drive(st_e, 1, 1, 0);
        check("flush_st_req", st_req, 1);
        tick();
        drive(st_e, 1, 1, 1);
        check("flush_st_pop", pop, 1);
        tick();
        drive(idle_e, 0, 0, 0);
        check("flush_cnt4", retired_cnt, 4);
        tick();

        // SYS status then halt; later ready heads stay parked.
        drive(sys_pass, 1, 0, 0);
        check("sys_pop", pop, 1);
        tick();
        drive(sys_done, 1, 0, 0);
        check("sys_pass_o", pass_o, 1);
        check("sys_done_pre", done_o, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(alu_t0, 1, 0, 0);
            check("halt_done_o", done_o, 1);
            check("halt_pop", pop, 0);
            check("halt_rf_we", rf_we, 0);
            tick();
        end
        drive(idle_e, 0, 0, 0);
        check("halt_cnt6", retired_cnt, 6);
        tick();

        // Unacknowledged store raises st_err after TMO cycles; reset drops everything at once.
        do_reset();
        drive(alu_t0, 1, 0, 0);
        tick();
        drive(st_e, 1, 0, 0);
        tick();
        for (int i = 0; i < TMO; i++) begin
            drive(st_e, 1, 0, 0);
            check("tmo_err_pre", st_err, 0);
            tick();
        end
        drive(st_e, 1, 0, 0);
        check("tmo_err_set", st_err, 1);
        check("tmo_still_req", st_req, 1);
        head_entry = alu_t0;
        rst_n = 0;
        #1;
        check("arst_st_req", st_req, 0);
        check("arst_st_err", st_err, 0);
        check("arst_pop", pop, 0);
        check("arst_rf_we", rf_we, 0);
        check("arst_waddr", rf_waddr, 0);
        check("arst_st_addr", st_addr, 0);
        check("arst_cnt", retired_cnt, 0);
        do_reset();

        // Randomized traffic, periodically reset to leave HALT.
        for (int ph = 0; ph < 10; ph++) begin
            for (int c = 0; c < 300; c++) begin
                drive(rand_entry(), ($urandom % 8) != 0, ($urandom % 8) == 0, ($urandom % 4) == 0);
                tick();
            end
            do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
